// File: rtl/ps2_host_writer_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter:
// state encoding, frame length, parity helper and default cycle constants.
// The optional watchdog is selected with the PS2_TX_TIMEOUT_EN macro.
package ps2_host_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_DONE      = 3'd6
    } ps2_tx_state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_LEN              = 11;
    // 100 us and 15 ms at a 50 MHz system clock
    localparam int DEFAULT_INHIBIT_CYCLES = 5000;
    localparam int DEFAULT_TIMEOUT_CYCLES = 750000;

    // Odd parity: data plus parity bit always carries an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_writer_if.sv
// CPU-side command interface of the PS/2 host writer.
//
// Handshake: the master raises txStart for one cycle with txData valid; the
// request is accepted only when busy is low in that cycle, otherwise it is
// dropped. busy/txActive rise the cycle after acceptance and stay high until
// the cycle after done. done pulses once per accepted request; ackOk and
// timeoutErr are valid with done and hold until the next accepted request.
interface ps2_host_writer_if;

    logic [7:0] txData;
    logic       txStart;
    logic       busy;
    logic       txActive;
    logic       done;
    logic       ackOk;
    logic       timeoutErr;

    modport master (
        output txData, txStart,
        input  busy, txActive, done, ackOk, timeoutErr
    );

    modport slave (
        input  txData, txStart,
        output busy, txActive, done, ackOk, timeoutErr
    );

endinterface

// File: rtl/ps2_host_writer_line_sync.sv
// Two-flop synchronizer for the raw PS/2 CLK and DATA lines plus a
// one-cycle strobe on each synchronized CLK falling edge. Lines idle high,
// so the flops reset to 1 to avoid a false edge after reset.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2ClkIn,
    input  logic ps2DataIn,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic clk_meta_q,  clk_meta_d;
    logic clk_sync_q,  clk_sync_d;
    logic clk_prev_q,  clk_prev_d;
    logic data_meta_q, data_meta_d;
    logic data_sync_q, data_sync_d;

    // Shift each line one stage per cycle through the synchronizer chain.
    always_comb begin
        clk_meta_d  = ps2ClkIn;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        data_meta_d = ps2DataIn;
        data_sync_d = data_meta_q;
    end

    // Synchronizer registers, released-line level on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
        end
    end

    assign clk_sync  = clk_sync_q;
    assign data_sync = data_sync_q;
    assign clk_fall  = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_writer.sv
// PS/2 host-to-device transmitter: request-to-send, odd-parity framing,
// device-clocked bit shifting and acknowledge check. Open-drain control is
// exported as "drive low" flags; the top level owns the tristates.
// Optional watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_host_writer
    import ps2_host_writer_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES
`ifdef PS2_TX_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ps2ClkIn,
    input  logic                   ps2DataIn,
    output logic                   ps2ClkLow,
    output logic                   ps2DataLow,
    ps2_host_writer_if.slave       tx,
    output ps2_tx_state_t          state_dbg
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

    logic clk_sync, data_sync, clk_fall;

    ps2_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .ps2ClkIn  (ps2ClkIn),
        .ps2DataIn (ps2DataIn),
        .clk_sync  (clk_sync),
        .data_sync (data_sync),
        .clk_fall  (clk_fall)
    );

    ps2_tx_state_t    state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    // Remaining bits after the start bit: data[0..7], parity, stop (LSB first).
    logic [9:0]       frame_q, frame_d;
    // Index of the frame bit presented on the next falling edge (1..10).
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             data_low_q, data_low_d;
    logic             ack_ok_q, ack_ok_d;
`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    // Next-state and datapath: transfer sequencing driven by the device clock.
    always_comb begin
        state_d    = state_q;
        inh_cnt_d  = inh_cnt_q;
        frame_d    = frame_q;
        bit_idx_d  = bit_idx_q;
        data_low_d = data_low_q;
        ack_ok_d   = ack_ok_q;
`ifdef PS2_TX_TIMEOUT_EN
        wd_cnt_d   = wd_cnt_q;
        timeout_d  = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                data_low_d = 1'b0;
                if (tx.txStart) begin
                    frame_d   = {1'b1, odd_parity(tx.txData), tx.txData};
                    inh_cnt_d = '0;
                    ack_ok_d  = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                inh_cnt_d = inh_cnt_q + 1'b1;
                if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    // Start bit goes out while CLK is still held for one cycle.
                    data_low_d = 1'b1;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                bit_idx_d = 4'd1;
`ifdef PS2_TX_TIMEOUT_EN
                wd_cnt_d  = '0;
`endif
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (clk_fall) begin
                    data_low_d = ~frame_q[0];
                    frame_d    = {1'b0, frame_q[9:1]};
                    if (bit_idx_q == 4'd10) begin
                        state_d = ST_ACK;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    ack_ok_d = ~data_sync;
                    state_d  = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                data_low_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        // The watchdog overrides whatever the device is doing on this cycle.
        if (state_q == ST_SEND || state_q == ST_ACK || state_q == ST_WAIT_IDLE) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
            if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                data_low_d = 1'b0;
                ack_ok_d   = 1'b0;
                timeout_d  = 1'b1;
                state_d    = ST_DONE;
            end
        end
`endif
    end

    // State and datapath registers; reset releases both lines at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            inh_cnt_q  <= '0;
            frame_q    <= '0;
            bit_idx_q  <= '0;
            data_low_q <= 1'b0;
            ack_ok_q   <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            inh_cnt_q  <= inh_cnt_d;
            frame_q    <= frame_d;
            bit_idx_q  <= bit_idx_d;
            data_low_q <= data_low_d;
            ack_ok_q   <= ack_ok_d;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt_q   <= wd_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign ps2ClkLow   = (state_q == ST_INHIBIT) || (state_q == ST_REQ);
    assign ps2DataLow  = data_low_q;
    assign tx.busy     = (state_q != ST_IDLE);
    assign tx.txActive = (state_q != ST_IDLE);
    assign tx.done     = (state_q == ST_DONE);
    assign tx.ackOk    = ack_ok_q;
`ifdef PS2_TX_TIMEOUT_EN
    assign tx.timeoutErr = timeout_q;
`else
    assign tx.timeoutErr = 1'b0;
`endif
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ps2_host_writer.sv
// Bench for ps2_host_writer: a device BFM clocks frames out of the host,
// a table of directed bytes plus random bytes checked against a frame model.
module tb_ps2_host_writer;
    import ps2_host_writer_pkg::*;

    localparam int INH  = 8;
    localparam int TO   = 200;
    localparam int HALF = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic ps2ClkLow, ps2DataLow;
    logic clk_line, data_line;
    ps2_tx_state_t state_dbg;

    // Open-drain wired-AND of host and device.
    assign clk_line  = dev_clk  & ~ps2ClkLow;
    assign data_line = dev_data & ~ps2DataLow;

    ps2_host_writer_if tx ();

    ps2_host_writer #(
        .INHIBIT_CYCLES(INH)
`ifdef PS2_TX_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2ClkIn   (clk_line),
        .ps2DataIn  (data_line),
        .ps2ClkLow  (ps2ClkLow),
        .ps2DataLow (ps2DataLow),
        .tx         (tx),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [10:0] exp_q[$];
    int done_cnt = 0;

    always @(posedge clk) begin
        if (!rst && tx.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame model: bit i of the result is the i-th bit on the wire.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            if (d[i]) ones++;
        end
        f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    // ---------------- device BFM ----------------
    logic [10:0] rx_frame;
    int inh_len, ovl_len;

    task automatic bfm(input logic do_ack, input int abort_at);
        int guard;
        rx_frame = '0;
        inh_len  = 0;
        ovl_len  = 0;
        guard    = 0;
        while (ps2ClkLow !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (ps2ClkLow !== 1'b1) begin
            check("rts_seen", ps2ClkLow, 1);
            return;
        end
        while (ps2ClkLow === 1'b1 && guard < 400) begin
            inh_len++;
            if (ps2DataLow === 1'b1) ovl_len++;
            @(negedge clk);
            guard++;
        end
        rx_frame[0] = data_line;
        for (int i = 1; i <= 10; i++) begin
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            rx_frame[i] = data_line;
            if (i == abort_at) return;
        end
        if (do_ack) dev_data = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_data = 1'b1;
    endtask

    // ---------------- host driver ----------------
    task automatic send_byte(input logic [7:0] d, input logic poke);
        @(negedge clk);
        tx.txData  = d;
        tx.txStart = 1'b1;
        @(negedge clk);
        tx.txStart = 1'b0;
        tx.txData  = 8'($urandom);
        check("busy_rise", tx.busy, 1);
        check("txactive_rise", tx.txActive, 1);
        if (poke) begin
            repeat (3) @(negedge clk);
            tx.txData  = 8'hAA;
            tx.txStart = 1'b1;
            @(negedge clk);
            tx.txStart = 1'b0;
        end
    endtask

    task automatic wait_done(output logic ack_ok, output logic to_err);
        int guard;
        guard  = 0;
        ack_ok = 1'b0;
        to_err = 1'b0;
        while (tx.done !== 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", tx.done, 1);
        if (tx.done !== 1'b1) return;
        ack_ok = tx.ackOk;
        to_err = tx.timeoutErr;
        check("lines_at_done", {ps2ClkLow, ps2DataLow}, 0);
        // Request in the done cycle must be dropped.
        tx.txData  = 8'h55;
        tx.txStart = 1'b1;
        @(negedge clk);
        tx.txStart = 1'b0;
        check("busy_fall", tx.busy, 0);
        check("done_one_cycle", tx.done, 0);
        @(negedge clk);
        check("start_in_done_ignored", tx.busy, 0);
    endtask

    task automatic do_transfer(input logic [7:0] d, input logic ack, input logic poke,
                               output logic ack_ok, output logic to_err);
        fork
            bfm(ack, 0);
            begin
                send_byte(d, poke);
                wait_done(ack_ok, to_err);
            end
        join
        check("inhibit_len", inh_len, INH + 1);
        check("req_overlap", ovl_len, 1);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0]  data;
        logic        ack;
        logic        poke;
        logic [10:0] exp_frame;
        logic        exp_ack;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic ack_ok, to_err;
        logic [10:0] f;
        logic [7:0] d;
        logic a;
        int cyc, guard, dc;

        // Frames are {stop, parity, data, start}; parity hand-derived:
        // ED has six ones -> 1, FF eight -> 1, 00 none -> 1, 01 one -> 0,
        // 5A four -> 1, 3C four -> 1.
        tbl[0] = '{8'hED, 1'b1, 1'b0, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b1};
        tbl[1] = '{8'hFF, 1'b1, 1'b0, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1};
        tbl[2] = '{8'h00, 1'b1, 1'b0, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b1};
        tbl[3] = '{8'h01, 1'b1, 1'b0, {1'b1, 1'b0, 8'h01, 1'b0}, 1'b1};
        tbl[4] = '{8'h5A, 1'b0, 1'b0, {1'b1, 1'b1, 8'h5A, 1'b0}, 1'b0};
        tbl[5] = '{8'h3C, 1'b1, 1'b1, {1'b1, 1'b1, 8'h3C, 1'b0}, 1'b1};

        tx.txData  = 8'h00;
        tx.txStart = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        check("rst_clklow", ps2ClkLow, 0);
        check("rst_datalow", ps2DataLow, 0);
        check("rst_busy", tx.busy, 0);
        check("rst_txactive", tx.txActive, 0);
        check("rst_done", tx.done, 0);
        check("rst_ackok", tx.ackOk, 0);
        check("rst_timeouterr", tx.timeoutErr, 0);

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            do_transfer(tbl[i].data, tbl[i].ack, tbl[i].poke, ack_ok, to_err);
            check($sformatf("tbl%0d_frame", i), rx_frame, tbl[i].exp_frame);
            check($sformatf("tbl%0d_ackok", i), ack_ok, tbl[i].exp_ack);
            check($sformatf("tbl%0d_timeouterr", i), to_err, 0);
            check($sformatf("tbl%0d_ackok_hold", i), tx.ackOk, tbl[i].exp_ack);
        end

        // Random bytes against the frame model.
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            a = 1'($urandom_range(0, 1));
            exp_q.push_back(model_frame(d));
            do_transfer(d, a, 1'b0, ack_ok, to_err);
            check($sformatf("rnd%0d_frame", i), rx_frame, exp_q.pop_front());
            check($sformatf("rnd%0d_ackok", i), ack_ok, a);
        end

        // Reset in the middle of SEND, after the device has clocked bit 4.
        dc = done_cnt;
        fork
            bfm(1'b1, 4);
            send_byte(8'h96, 1'b0);
        join
        f = model_frame(8'h96);
        check("abort_partial_frame", rx_frame[4:0], f[4:0]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_clklow", ps2ClkLow, 0);
        check("abort_datalow", ps2DataLow, 0);
        check("abort_busy", tx.busy, 0);
        check("abort_done", tx.done, 0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("abort_no_done", done_cnt, dc);
        check("abort_still_idle", tx.busy, 0);

        do_transfer(8'hF4, 1'b1, 1'b0, ack_ok, to_err);
        check("f4_frame", rx_frame, {1'b1, 1'b0, 8'hF4, 1'b0});
        check("f4_ackok", ack_ok, 1);

        // Silent device: the host never sees a clock edge.
        send_byte(8'h42, 1'b0);
        guard = 0;
        while (ps2ClkLow !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("silent_release", ps2ClkLow, 0);
`ifdef PS2_TX_TIMEOUT_EN
        cyc = 0;
        while (tx.done !== 1'b1 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycles", cyc, TO);
        check("timeout_err", tx.timeoutErr, 1);
        check("timeout_ackok", tx.ackOk, 0);
        check("timeout_lines", {ps2ClkLow, ps2DataLow}, 0);
        @(negedge clk);
        check("timeout_busy_fall", tx.busy, 0);
        check("timeout_err_hold", tx.timeoutErr, 1);
`else
        cyc = 0;
        repeat (3 * TO / 2) @(negedge clk);
        check("silent_busy_held", tx.busy, 1);
        check("silent_start_bit_held", ps2DataLow, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("silent_rst_busy", tx.busy, 0);
        check("silent_rst_lines", {ps2ClkLow, ps2DataLow}, 0);
        check("silent_timeouterr", tx.timeoutErr, 0);
        check("silent_cycle_count", cyc, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
